mmio_timer: RTL and testbench

Memory-mapped machine timer that responds to the core's data-memory port, alongside the data RAM, behind the address decoder. It holds a 64-bit free-running counter (mtime) with a programmable prescaler and a 64-bit compare register (mtimecmp). When the counter reaches the compare value it raises a sticky, maskable interrupt toward the core. Register reads use the same one-cycle registered read latency as the data RAM, so the core's load path needs no changes.

---
 rtl/mmio_timer.sv | 209 ++++++++++++++++++++
 tb/tb_mmio_timer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mmio_timer.sv
`default_nettype none
// ============================================================================
// Module   : mmio_timer
// Purpose  : Memory-mapped machine timer. It holds a 64-bit free-running
//            counter (mtime) driven by a programmable 8-bit prescaler, and a
//            64-bit compare register (mtimecmp). It raises a sticky, maskable,
//            registered interrupt when mtime >= mtimecmp. Reads have a
//            one-cycle registered latency. The read data is forced to zero
//            when the timer is not being read, so it can be OR-combined with
//            the data RAM read bus.
// Ports    : i_clk       system clock (rising edge)
//            i_rst_n     asynchronous active-low reset
//            i_sel       chip select from the address decoder
//            i_we        write strobe (qualified by i_sel)
//            i_addr      word offset inside the timer window
//            i_wrdata    write data
//            o_rdata     registered read data (0 when not reading)
//            o_irq       registered level interrupt (PENDING & IRQ_EN)
// Register map (word offset):
//            0 CTRL        bit0 EN, bit1 IRQ_EN, bits[15:8] PRESCALE
//            1 STATUS      bit0 PENDING (write 1 to clear)
//            2 MTIME_LO    3 MTIME_HI (returns shadow captured by LO read)
//            4 MTIMECMP_LO 5 MTIMECMP_HI
//            6,7           read as 0, writes ignored
// Revision : 1.0  initial release
// ============================================================================
module mmio_timer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_sel,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wrdata,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_irq
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL     = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MTIME_LO = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MTIME_HI = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] ADDR_CMP_LO   = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] ADDR_CMP_HI   = ADDR_WIDTH'(5);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                  ctrl_en_q,       ctrl_en_d;
    logic                  ctrl_irq_en_q,   ctrl_irq_en_d;
    logic [7:0]            ctrl_prescale_q, ctrl_prescale_d;
    logic [7:0]            presc_cnt_q,     presc_cnt_d;
    logic                  pending_q,       pending_d;
    logic [63:0]           mtime_q,         mtime_d;
    logic [63:0]           mtimecmp_q,      mtimecmp_d;
    logic [31:0]           hi_shadow_q,     hi_shadow_d;
    logic [DATA_WIDTH-1:0] rdata_q,         rdata_d;
    logic                  irq_q,           irq_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                  bus_wr;
    logic                  bus_rd;
    logic                  tick;
    logic                  hit;
    logic [DATA_WIDTH-1:0] rd_mux;

    assign bus_wr = i_sel & i_we;
    assign bus_rd = i_sel & ~i_we;

    // The counter normally never exceeds PRESCALE. The >= guards the case
    // where software lowers PRESCALE below the current count: the next tick
    // comes at once instead of after a full 256-cycle wrap.
    assign tick = ctrl_en_q && (presc_cnt_q >= ctrl_prescale_q);

    // Compare on registered values only, so PENDING trails the match by one
    // edge and o_irq by two.
    assign hit = (mtime_q >= mtimecmp_q);

    // ------------------------------------------------------------------
    // Control register
    // ------------------------------------------------------------------
    always_comb begin
        ctrl_en_d       = ctrl_en_q;
        ctrl_irq_en_d   = ctrl_irq_en_q;
        ctrl_prescale_d = ctrl_prescale_q;
        if (bus_wr && (i_addr == ADDR_CTRL)) begin
            ctrl_en_d       = i_wrdata[0];
            ctrl_irq_en_d   = i_wrdata[1];
            ctrl_prescale_d = i_wrdata[15:8];
        end
    end

    // ------------------------------------------------------------------
    // Prescaler: counts 0..PRESCALE while enabled, parked at 0 otherwise
    // ------------------------------------------------------------------
    always_comb begin
        presc_cnt_d = presc_cnt_q;
        if (!ctrl_en_q || tick) begin
            presc_cnt_d = 8'd0;
        end else begin
            presc_cnt_d = presc_cnt_q + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // mtime: a bus write to either half wins over the increment, and the
    // other half is left untouched that cycle (no carry propagation).
    // ------------------------------------------------------------------
    always_comb begin
        mtime_d = mtime_q + {63'd0, tick};
        if (bus_wr && (i_addr == ADDR_MTIME_LO)) begin
            mtime_d = {mtime_q[63:32], i_wrdata};
        end else if (bus_wr && (i_addr == ADDR_MTIME_HI)) begin
            mtime_d = {i_wrdata, mtime_q[31:0]};
        end
    end

    // ------------------------------------------------------------------
    // mtimecmp
    // ------------------------------------------------------------------
    always_comb begin
        mtimecmp_d = mtimecmp_q;
        if (bus_wr && (i_addr == ADDR_CMP_LO)) begin
            mtimecmp_d = {mtimecmp_q[63:32], i_wrdata};
        end else if (bus_wr && (i_addr == ADDR_CMP_HI)) begin
            mtimecmp_d = {i_wrdata, mtimecmp_q[31:0]};
        end
    end

    // ------------------------------------------------------------------
    // PENDING: sticky; a set in the same cycle beats a W1C clear
    // ------------------------------------------------------------------
    always_comb begin
        pending_d = pending_q;
        if (hit) begin
            pending_d = 1'b1;
        end else if (bus_wr && (i_addr == ADDR_STATUS) && i_wrdata[0]) begin
            pending_d = 1'b0;
        end
    end

    assign irq_d = pending_q & ctrl_irq_en_q;

    // ------------------------------------------------------------------
    // Read path. A read of MTIME_LO snapshots the upper half so a later
    // MTIME_HI read forms a coherent 64-bit pair with it.
    // ------------------------------------------------------------------
    always_comb begin
        hi_shadow_d = hi_shadow_q;
        if (bus_rd && (i_addr == ADDR_MTIME_LO)) begin
            hi_shadow_d = mtime_q[63:32];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (i_addr)
            ADDR_CTRL:     rd_mux = {16'd0, ctrl_prescale_q, 6'd0,
                                     ctrl_irq_en_q, ctrl_en_q};
            ADDR_STATUS:   rd_mux = {31'd0, pending_q};
            ADDR_MTIME_LO: rd_mux = mtime_q[31:0];
            ADDR_MTIME_HI: rd_mux = hi_shadow_q;
            ADDR_CMP_LO:   rd_mux = mtimecmp_q[31:0];
            ADDR_CMP_HI:   rd_mux = mtimecmp_q[63:32];
            default:       rd_mux = '0;
        endcase
    end

    // Zero when not reading so the bus can be OR-combined with RAM data.
    assign rdata_d = bus_rd ? rd_mux : '0;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ctrl_en_q       <= 1'b0;
            ctrl_irq_en_q   <= 1'b0;
            ctrl_prescale_q <= 8'd0;
            presc_cnt_q     <= 8'd0;
            pending_q       <= 1'b0;
            mtime_q         <= 64'd0;
            mtimecmp_q      <= 64'hFFFF_FFFF_FFFF_FFFF;
            hi_shadow_q     <= 32'd0;
            rdata_q         <= '0;
            irq_q           <= 1'b0;
        end else begin
            ctrl_en_q       <= ctrl_en_d;
            ctrl_irq_en_q   <= ctrl_irq_en_d;
            ctrl_prescale_q <= ctrl_prescale_d;
            presc_cnt_q     <= presc_cnt_d;
            pending_q       <= pending_d;
            mtime_q         <= mtime_d;
            mtimecmp_q      <= mtimecmp_d;
            hi_shadow_q     <= hi_shadow_d;
            rdata_q         <= rdata_d;
            irq_q           <= irq_d;
        end
    end

    assign o_rdata = rdata_q;
    assign o_irq   = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_mmio_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_timer
// Purpose  : Directed, self-checking bench for mmio_timer. Each bus task
//            occupies exactly one rising edge and returns 1 time unit after
//            it, so all expected values below are counted in edges.
// Revision : 1.0  initial release
// ============================================================================
module tb_mmio_timer;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int total;
    int bad;
    logic [31:0] rv;

    mmio_timer #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (3)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_sel    (sel),
        .i_we     (we),
        .i_addr   (addr),
        .i_wrdata (wdata),
        .o_rdata  (rdata),
        .o_irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
        sel = 1'b1; we = 1'b0; addr = a;
        @(posedge clk); #1;
        sel = 1'b0;
        d = rdata;
    endtask

    task automatic idle(input int n);
        sel = 1'b0; we = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; sel = 1'b0; we = 1'b0; addr = 3'd0; wdata = 32'd0;
        #12;
        check("reset_rdata", rdata, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        idle(1);
        bus_rd(3'd5, rv); check("reset_cmp_hi", rv, 32'hFFFF_FFFF);
        bus_rd(3'd1, rv); check("reset_status", rv, 32'd0);

        // ---- Prescaler = 3: mtime after k edges past the enable is k/4
        bus_wr(3'd0, 32'h0000_0301);
        idle(40);
        bus_rd(3'd2, rv); check("presc3_mtime", rv, 32'd10);
        bus_rd(3'd0, rv); check("ctrl_readback", rv, 32'h0000_0301);

        // ---- Prescaler = 0: one tick per cycle
        bus_wr(3'd0, 32'h0);
        bus_wr(3'd2, 32'h0);
        bus_wr(3'd0, 32'h0000_0001);
        idle(40);
        bus_rd(3'd2, rv); check("presc0_mtime", rv, 32'd40);

        // ---- Write to MTIME_LO wins over the increment
        bus_wr(3'd2, 32'h0000_0100);
        bus_rd(3'd2, rv); check("wr_lo_no_inc", rv, 32'h0000_0100);
        bus_rd(3'd2, rv); check("lo_after_inc", rv, 32'h0000_0101);

        // ---- Carry and coherent 64-bit read
        bus_wr(3'd0, 32'h0);
        bus_wr(3'd3, 32'h0000_0001);
        bus_wr(3'd2, 32'hFFFF_FFFE);
        bus_wr(3'd0, 32'h0000_0001);
        idle(1);
        bus_rd(3'd2, rv); check("coh_lo", rv, 32'hFFFF_FFFF);
        idle(1);
        bus_rd(3'd3, rv); check("coh_hi_shadow", rv, 32'h0000_0001);
        bus_rd(3'd2, rv); check("carry_lo", rv, 32'h0000_0002);
        bus_rd(3'd3, rv); check("carry_hi", rv, 32'h0000_0002);

        // ---- Compare interrupt (mtime after k edges past CTRL write = k)
        bus_wr(3'd0, 32'h0);
        bus_wr(3'd2, 32'h0);
        bus_wr(3'd3, 32'h0);
        bus_wr(3'd4, 32'd20);
        bus_wr(3'd5, 32'h0);
        bus_wr(3'd0, 32'h0000_0003);
        idle(20);
        check("irq_at_match", {31'd0, irq}, 32'd0);
        bus_rd(3'd1, rv); check("pend_at_match", rv, 32'd0);
        check("irq_match_p1", {31'd0, irq}, 32'd0);
        bus_rd(3'd1, rv); check("pend_rise", rv, 32'd1);
        check("irq_rise", {31'd0, irq}, 32'd1);
        bus_wr(3'd1, 32'h1);
        bus_rd(3'd1, rv); check("w1c_set_wins", rv, 32'd1);
        check("irq_held", {31'd0, irq}, 32'd1);
        bus_wr(3'd5, 32'h1);
        bus_wr(3'd1, 32'h1);
        check("irq_w1c_edge", {31'd0, irq}, 32'd1);
        idle(1);
        check("irq_fall", {31'd0, irq}, 32'd0);
        bus_rd(3'd1, rv); check("pend_cleared", rv, 32'd0);

        // ---- Masking
        bus_wr(3'd0, 32'h0);
        bus_wr(3'd2, 32'h0);
        bus_wr(3'd5, 32'h0);
        bus_wr(3'd0, 32'h0000_0001);
        idle(25);
        bus_rd(3'd1, rv); check("mask_pend", rv, 32'd1);
        check("mask_irq_low", {31'd0, irq}, 32'd0);
        idle(3);
        check("mask_irq_still_low", {31'd0, irq}, 32'd0);
        bus_wr(3'd0, 32'h0000_0003);
        check("unmask_irq_edge", {31'd0, irq}, 32'd0);
        idle(1);
        check("unmask_irq_rise", {31'd0, irq}, 32'd1);

        // ---- Bus edge cases
        sel = 1'b0; we = 1'b1; addr = 3'd4; wdata = 32'h5555_5555;
        @(posedge clk); #1;
        we = 1'b0;
        bus_rd(3'd4, rv); check("nosel_write_ignored", rv, 32'd20);
        idle(1);
        check("nosel_rdata_zero", rdata, 32'd0);
        bus_wr(3'd6, 32'h1234_5678);
        check("write_cycle_rdata_zero", rdata, 32'd0);
        bus_rd(3'd6, rv); check("offset6_zero", rv, 32'd0);
        bus_wr(3'd0, 32'hFFFF_FFFF);
        bus_rd(3'd0, rv); check("ctrl_mask_bits", rv, 32'h0000_FF03);

        // ---- Asynchronous reset mid-count with irq and rdata active
        bus_rd(3'd4, rv); check("pre_reset_rdata", rv, 32'd20);
        check("pre_reset_irq", {31'd0, irq}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rdata", rdata, 32'd0);
        check("async_rst_irq", {31'd0, irq}, 32'd0);
        #10 rst_n = 1'b1;
        idle(1);
        bus_rd(3'd4, rv); check("post_rst_cmp_lo", rv, 32'hFFFF_FFFF);
        bus_rd(3'd2, rv); check("post_rst_mtime_lo", rv, 32'd0);
        bus_rd(3'd0, rv); check("post_rst_ctrl", rv, 32'd0);
        bus_rd(3'd1, rv); check("post_rst_status", rv, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
